// File: rtl/instr_aligner_if.sv
// ---------------------------------------------------------------------------
// instr_aligner_if
//   Bundles the fetch-side and decode-side signals of the instruction aligner.
//   master : the fetch/decode environment (drives fetch word, flush, id_stall)
//   slave  : the aligner itself
// Signals
//   fetch_valid    fetch_word/fetch_pc valid this cycle
//   fetch_pc[32]   pc of the fetch word (pc[1]=1 only right after a redirect)
//   fetch_word[32] [15:0] halfword at pc&~3, [31:16] halfword at (pc&~3)+2
//   flush          redirect this cycle, drop all buffered state
//   id_stall       decode cannot accept, outputs must hold
//   fetch_stall    current word not consumed, fetch re-presents it
//   id_valid       id_instr holds a valid instruction
//   id_pc[32]      pc of id_instr
//   id_instr[32]   instruction, compressed ones zero-extended
//   id_compressed  id_instr is a 16-bit instruction
// ---------------------------------------------------------------------------
interface instr_aligner_if;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_word;
    logic        flush;
    logic        id_stall;
    logic        fetch_stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_compressed;

    modport master (
        output fetch_valid, fetch_pc, fetch_word, flush, id_stall,
        input  fetch_stall, id_valid, id_pc, id_instr, id_compressed
    );

    modport slave (
        input  fetch_valid, fetch_pc, fetch_word, flush, id_stall,
        output fetch_stall, id_valid, id_pc, id_instr, id_compressed
    );
endinterface

// File: rtl/instr_aligner.sv
// ---------------------------------------------------------------------------
// instr_aligner
//   Sits between fetch and decode for RV32IC. Takes word-aligned 32-bit fetch
//   words and emits one aligned instruction per cycle (16-bit or 32-bit),
//   reassembling 32-bit instructions that straddle a word boundary. When one
//   word carries two instructions it holds fetch for a cycle (fetch_stall).
// Parameters
//   SUPPORT_C  1: RV32IC alignment; 0: every word is one 32-bit instruction
// Ports
//   clk    clock, all state on posedge
//   reset  synchronous, active-high
//   bus    instr_aligner_if.slave (fetch inputs, fetch_stall, id_* outputs)
// ---------------------------------------------------------------------------
module instr_aligner #(
    parameter bit SUPPORT_C = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    instr_aligner_if.slave   bus
);

    // Buffered low half of a 32-bit instruction whose high half is in the next word
    logic        part_v_q,  part_v_d;
    logic [15:0] part_hw_q, part_hw_d;
    logic [31:0] part_pc_q, part_pc_d;
    // Low half of the current word was already emitted; only hi is left
    logic        lo_done_q, lo_done_d;

    logic        id_valid_q,      id_valid_d;
    logic [31:0] id_pc_q,         id_pc_d;
    logic [31:0] id_instr_q,      id_instr_d;
    logic        id_compressed_q, id_compressed_d;

    logic        fetch_stall_c;
    logic        take_hi;

    logic [15:0] lo_hw;
    logic [15:0] hi_hw;
    logic        lo_c;
    logic        hi_c;
    logic        start_hi;
    logic [31:0] word_pc;
    logic [31:0] hi_pc;

    assign lo_hw    = bus.fetch_word[15:0];
    assign hi_hw    = bus.fetch_word[31:16];
    assign lo_c     = (lo_hw[1:0] != 2'b11);
    assign hi_c     = (hi_hw[1:0] != 2'b11);
    // Decoding starts at the high halfword after a redirect to pc[1]=1 or
    // once the low compressed instruction of this word has gone out.
    assign start_hi = bus.fetch_pc[1] | lo_done_q;
    assign word_pc  = {bus.fetch_pc[31:2], 2'b00};
    assign hi_pc    = {bus.fetch_pc[31:2], 2'b10};

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        part_v_d        = part_v_q;
        part_hw_d       = part_hw_q;
        part_pc_d       = part_pc_q;
        lo_done_d       = lo_done_q;
        id_valid_d      = id_valid_q;
        id_pc_d         = id_pc_q;
        id_instr_d      = id_instr_q;
        id_compressed_d = id_compressed_q;
        fetch_stall_c   = 1'b0;
        take_hi         = 1'b0;

        if (bus.flush) begin
            // Redirect wins over everything: drop buffered state and the word.
            part_v_d   = 1'b0;
            lo_done_d  = 1'b0;
            id_valid_d = 1'b0;
        end else if (bus.id_stall) begin
            fetch_stall_c = bus.fetch_valid;
        end else if (!bus.fetch_valid) begin
            id_valid_d = 1'b0;
        end else if (!SUPPORT_C) begin
            id_valid_d      = 1'b1;
            id_pc_d         = word_pc;
            id_instr_d      = bus.fetch_word;
            id_compressed_d = 1'b0;
        end else if (part_v_q) begin
            // Low half of this word completes the buffered instruction.
            id_valid_d      = 1'b1;
            id_pc_d         = part_pc_q;
            id_instr_d      = {lo_hw, part_hw_q};
            id_compressed_d = 1'b0;
            take_hi         = 1'b1;
        end else if (!start_hi) begin
            if (lo_c) begin
                id_valid_d      = 1'b1;
                id_pc_d         = word_pc;
                id_instr_d      = {16'h0000, lo_hw};
                id_compressed_d = 1'b1;
                take_hi         = 1'b1;
            end else begin
                id_valid_d      = 1'b1;
                id_pc_d         = word_pc;
                id_instr_d      = bus.fetch_word;
                id_compressed_d = 1'b0;
                lo_done_d       = 1'b0;
            end
        end else if (hi_c) begin
            id_valid_d      = 1'b1;
            id_pc_d         = hi_pc;
            id_instr_d      = {16'h0000, hi_hw};
            id_compressed_d = 1'b1;
            lo_done_d       = 1'b0;
        end else begin
            // High half starts a 32-bit instruction: buffer it, nothing to emit.
            id_valid_d = 1'b0;
            part_v_d   = 1'b1;
            part_hw_d  = hi_hw;
            part_pc_d  = hi_pc;
            lo_done_d  = 1'b0;
        end

        // The high halfword after the low half has been used this cycle.
        if (take_hi) begin
            if (hi_c) begin
                // A second instruction sits in this word: keep the word for one more cycle.
                fetch_stall_c = 1'b1;
                lo_done_d     = 1'b1;
                part_v_d      = 1'b0;
            end else begin
                part_v_d  = 1'b1;
                part_hw_d = hi_hw;
                part_pc_d = hi_pc;
                lo_done_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (reset) begin
            part_v_q        <= 1'b0;
            part_hw_q       <= 16'h0000;
            part_pc_q       <= 32'h0000_0000;
            lo_done_q       <= 1'b0;
            id_valid_q      <= 1'b0;
            id_pc_q         <= 32'h0000_0000;
            id_instr_q      <= 32'h0000_0000;
            id_compressed_q <= 1'b0;
        end else begin
            part_v_q        <= part_v_d;
            part_hw_q       <= part_hw_d;
            part_pc_q       <= part_pc_d;
            lo_done_q       <= lo_done_d;
            id_valid_q      <= id_valid_d;
            id_pc_q         <= id_pc_d;
            id_instr_q      <= id_instr_d;
            id_compressed_q <= id_compressed_d;
        end
    end

    assign bus.fetch_stall   = fetch_stall_c;
    assign bus.id_valid      = id_valid_q;
    assign bus.id_pc         = id_pc_q;
    assign bus.id_instr      = id_instr_q;
    assign bus.id_compressed = id_compressed_q;

endmodule

// File: tb/tb_instr_aligner.sv
// ---------------------------------------------------------------------------
// tb_instr_aligner
//   Self-checking bench for instr_aligner. The bench acts as the fetch unit
//   over a small halfword memory; a reference model walks the halfword stream
//   from the segment's start pc and queues the instructions decode must see.
//   A monitor pops that queue whenever decode accepts an instruction.
// ---------------------------------------------------------------------------
module tb_instr_aligner;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    instr_aligner_if bus ();

    instr_aligner #(.SUPPORT_C(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        c;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        exp_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] mem_hw [0:127];
    int          ends_cnt [0:63];
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: walk halfwords from the start pc; an instruction is expected
    // only if all of its halfwords lie inside the fetched words.
    task automatic build_expect(input logic [31:0] start_pc, input int nwords);
        logic [31:0] base;
        logic [15:0] hw;
        int          p;
        exp_t        e;
        base = {start_pc[31:2], 2'b00};
        for (int i = 0; i < nwords; i++) ends_cnt[i] = 0;
        p = start_pc[1] ? 1 : 0;
        while (p < 2 * nwords) begin
            hw = mem_hw[p];
            if (hw[1:0] != 2'b11) begin
                e.pc = base + 32'(2 * p); e.instr = {16'h0000, hw}; e.c = 1'b1;
                exp_q.push_back(e);
                ends_cnt[p / 2]++;
                p += 1;
            end else if (p + 1 < 2 * nwords) begin
                e.pc = base + 32'(2 * p); e.instr = {mem_hw[p + 1], hw}; e.c = 1'b0;
                exp_q.push_back(e);
                ends_cnt[(p + 1) / 2]++;
                p += 2;
            end else begin
                break;
            end
        end
    endtask

    // Present nwords words starting at start_pc. A word needs one accepted
    // cycle per instruction that ends in it (at least one), so fetch_stall is
    // expected high on every accepted cycle but the last.
    task automatic run_segment(input logic [31:0] start_pc, input int nwords,
                               input bit directed, input int stall_at, input int stall_len);
        logic [31:0] base;
        int          cyc;
        int          needed;
        int          count;
        bit          fv;
        bit          ist;
        base = {start_pc[31:2], 2'b00};
        build_expect(start_pc, nwords);
        cyc = 0;
        for (int w = 0; w < nwords; w++) begin
            needed = (ends_cnt[w] > 1) ? ends_cnt[w] : 1;
            count  = 0;
            while (count < needed) begin
                if (directed) begin
                    fv  = 1'b1;
                    ist = (cyc >= stall_at) && (cyc < stall_at + stall_len);
                end else begin
                    fv  = ($urandom_range(0, 9) < 8);
                    ist = ($urandom_range(0, 9) < 2);
                end
                @(posedge clk); #1;
                bus.fetch_valid = fv;
                bus.fetch_pc    = (w == 0) ? start_pc : base + 32'(4 * w);
                bus.fetch_word  = {mem_hw[2 * w + 1], mem_hw[2 * w]};
                bus.flush       = 1'b0;
                bus.id_stall    = ist;
                @(negedge clk);
                check("fetch_stall", {31'b0, bus.fetch_stall},
                      {31'b0, ist ? fv : (fv && (count + 1 < needed))});
                if (fv && !ist) count++;
                cyc++;
            end
        end
    endtask

    // Close a segment with a redirect (flush) or a synchronous reset.
    task automatic end_segment(input bit use_reset);
        @(posedge clk); #1;
        bus.fetch_valid = 1'(use_reset ? 0 : $urandom_range(0, 1));
        bus.fetch_word  = $urandom;
        bus.fetch_pc    = $urandom;
        bus.id_stall    = 1'b0;
        if (use_reset) reset = 1'b1;
        else           bus.flush = 1'b1;
        @(negedge clk);
        if (!use_reset) check("flush_fetch_stall", {31'b0, bus.fetch_stall}, 32'h0);
        @(posedge clk); #1;
        reset           = 1'b0;
        bus.flush       = 1'b0;
        bus.fetch_valid = 1'b0;
        @(negedge clk);
        check("post_redirect_id_valid", {31'b0, bus.id_valid}, 32'h0);
        if (use_reset) begin
            check("post_reset_id_pc", bus.id_pc, 32'h0);
            check("post_reset_id_instr", bus.id_instr, 32'h0);
        end
    endtask

    task automatic fill_random(input int nwords);
        logic [15:0] hw;
        for (int i = 0; i < 2 * nwords; i++) begin
            hw = 16'($urandom);
            if ($urandom_range(0, 1) == 1) hw[1:0] = 2'($urandom_range(0, 2));
            else                           hw[1:0] = 2'b11;
            mem_hw[i] = hw;
        end
    endtask

    // Monitor: decode accepts when id_valid & !id_stall; a stalled output must hold.
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    logic        prev_c;
    logic        prev_hold = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_hold) begin
                check("hold_id_valid", {31'b0, bus.id_valid}, 32'h1);
                check("hold_id_pc", bus.id_pc, prev_pc);
                check("hold_id_instr", bus.id_instr, prev_instr);
            end
            if (bus.id_valid && !bus.id_stall) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got pc 0x%08h instr 0x%08h, expected none",
                             bus.id_pc, bus.id_instr);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("id_pc", bus.id_pc, exp_e.pc);
                    check("id_instr", bus.id_instr, exp_e.instr);
                    check("id_compressed", {31'b0, bus.id_compressed}, {31'b0, exp_e.c});
                end
            end
            prev_hold  = bus.id_valid && bus.id_stall && !bus.flush && !reset;
            prev_pc    = bus.id_pc;
            prev_instr = bus.id_instr;
            prev_c     = bus.id_compressed;
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw;
        reset           = 1'b1;
        bus.fetch_valid = 1'b0;
        bus.fetch_pc    = 32'h0;
        bus.fetch_word  = 32'h0;
        bus.flush       = 1'b0;
        bus.id_stall    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_id_valid", {31'b0, bus.id_valid}, 32'h0);
        check("reset_id_pc", bus.id_pc, 32'h0);
        check("reset_id_instr", bus.id_instr, 32'h0);
        check("reset_id_compressed", {31'b0, bus.id_compressed}, 32'h0);
        check("reset_fetch_stall", {31'b0, bus.fetch_stall}, 32'h0);
        @(posedge clk); #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Plain 32-bit word
        mem_hw[0] = 16'h0013; mem_hw[1] = 16'h0000;
        run_segment(32'h0, 1, 1'b1, -1, 0);
        end_segment(1'b0);
        // Two compressed instructions in one word
        mem_hw[0] = 16'h4505; mem_hw[1] = 16'h4501;
        run_segment(32'h0, 1, 1'b1, -1, 0);
        end_segment(1'b0);
        // Straddling 32-bit instruction reassembled
        mem_hw[0] = 16'h4505; mem_hw[1] = 16'h0013; mem_hw[2] = 16'h0000; mem_hw[3] = 16'h4505;
        run_segment(32'h0, 2, 1'b1, -1, 0);
        end_segment(1'b0);
        // Redirect to pc[1]=1, compressed high half
        mem_hw[0] = 16'hABCD; mem_hw[1] = 16'h4505;
        run_segment(32'h2, 1, 1'b1, -1, 0);
        end_segment(1'b0);
        // Redirect to pc[1]=1, 32-bit instruction completed by the next word
        mem_hw[0] = 16'h1234; mem_hw[1] = 16'h0013; mem_hw[2] = 16'h0000; mem_hw[3] = 16'h4501;
        run_segment(32'h2, 2, 1'b1, -1, 0);
        end_segment(1'b0);
        // Decode stall for 3 cycles between the two halves of a double word
        mem_hw[0] = 16'h4505; mem_hw[1] = 16'h4501;
        run_segment(32'h0, 1, 1'b1, 1, 3);
        end_segment(1'b0);
        // Flush with a buffered halfword, then a lone word at 0x100
        mem_hw[0] = 16'h4505; mem_hw[1] = 16'h0013;
        run_segment(32'h0, 1, 1'b1, -1, 0);
        end_segment(1'b0);
        mem_hw[0] = 16'h0013; mem_hw[1] = 16'h0000;
        run_segment(32'h100, 1, 1'b1, -1, 0);
        end_segment(1'b0);
        // Reset with a buffered halfword
        mem_hw[0] = 16'h4505; mem_hw[1] = 16'h0013;
        run_segment(32'h40, 1, 1'b1, -1, 0);
        end_segment(1'b1);

        // Randomized segments with bubbles and decode stalls
        for (int s = 0; s < 60; s++) begin
            nw = $urandom_range(1, 8);
            fill_random(nw);
            run_segment({$urandom_range(0, 32'h3FFF), 1'($urandom_range(0, 1)), 1'b0},
                        nw, 1'b0, -1, 0);
            end_segment($urandom_range(0, 9) == 0);
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        check("drain_queue_empty", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
